// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes LSB loads, committed ROB stores and instruction fetches
// onto a byte-wide synchronous RAM port. Priority: store > load > fetch.
module mem_ctrl #(
    parameter int XLEN           = 32,
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int INST_OP_WIDTH  = 6,
    // Op encodings; must match the global op numbering used by the LSB/ROB
    parameter logic [INST_OP_WIDTH-1:0] OP_LB  = INST_OP_WIDTH'(11),
    parameter logic [INST_OP_WIDTH-1:0] OP_LH  = INST_OP_WIDTH'(12),
    parameter logic [INST_OP_WIDTH-1:0] OP_LW  = INST_OP_WIDTH'(13),
    parameter logic [INST_OP_WIDTH-1:0] OP_LBU = INST_OP_WIDTH'(14),
    parameter logic [INST_OP_WIDTH-1:0] OP_LHU = INST_OP_WIDTH'(15),
    parameter logic [INST_OP_WIDTH-1:0] OP_SB  = INST_OP_WIDTH'(16),
    parameter logic [INST_OP_WIDTH-1:0] OP_SH  = INST_OP_WIDTH'(17),
    parameter logic [INST_OP_WIDTH-1:0] OP_SW  = INST_OP_WIDTH'(18)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      lsb_ready,
    input  logic [INST_OP_WIDTH-1:0]  lsb_op,
    input  logic [XLEN-1:0]           lsb_addr,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,
    input  logic                      rob_st_valid,
    input  logic [INST_OP_WIDTH-1:0]  rob_st_op,
    input  logic [XLEN-1:0]           rob_st_addr,
    input  logic [XLEN-1:0]           rob_st_data,
    input  logic                      if_req,
    input  logic [XLEN-1:0]           if_addr,
    input  logic                      io_buffer_full,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [XLEN-1:0]           mem_a,
    output logic                      mem_wr,
    output logic                      mem_busy,
    output logic                      mem_data_ready,
    output logic [XLEN-1:0]           mem_data,
    output logic [ROB_SIZE_WIDTH-1:0] mem_id,
    output logic                      mem_st_done,
    output logic                      if_ready,
    output logic [XLEN-1:0]           if_inst
);

    localparam logic [XLEN-1:0] IO_BASE = XLEN'(32'h0003_0000);

    typedef enum logic [1:0] {IDLE, WRITE, READ_LD, READ_IF} state_t;

    state_t                    state;
    logic [2:0]                cnt;
    logic [2:0]                acc_len;
    logic [INST_OP_WIDTH-1:0]  acc_op;
    logic [ROB_SIZE_WIDTH-1:0] acc_id;
    logic [XLEN-1:0]           acc_data;

    logic                      slot_vld;
    logic [INST_OP_WIDTH-1:0]  slot_op;
    logic [XLEN-1:0]           slot_addr;
    logic [ROB_SIZE_WIDTH-1:0] slot_id;

    logic                      st_go, ld_go, if_go, ld_done;
    logic [INST_OP_WIDTH-1:0]  ld_op;
    logic [XLEN-1:0]           ld_addr;
    logic [ROB_SIZE_WIDTH-1:0] ld_id;
    logic [XLEN-1:0]           rd_word;

    function automatic logic [2:0] op_len(input logic [INST_OP_WIDTH-1:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 3'd1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 3'd2;
        return 3'd4;
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [INST_OP_WIDTH-1:0] op,
                                                 input logic [XLEN-1:0] raw);
        if (op == OP_LB)  return {{(XLEN-8){raw[7]}}, raw[7:0]};
        if (op == OP_LBU) return {{(XLEN-8){1'b0}}, raw[7:0]};
        if (op == OP_LH)  return {{(XLEN-16){raw[15]}}, raw[15:0]};
        if (op == OP_LHU) return {{(XLEN-16){1'b0}}, raw[15:0]};
        return raw;
    endfunction

    // IO-space writes stall while the IO buffer reports full
    function automatic logic io_hold(input logic full, input logic [XLEN-1:0] addr);
        return full && (addr >= IO_BASE);
    endfunction

    // Arbitration and read-byte assembly; a fresh lsb_ready bypasses the slot
    always_comb begin
        ld_op   = lsb_ready ? lsb_op   : slot_op;
        ld_addr = lsb_ready ? lsb_addr : slot_addr;
        ld_id   = lsb_ready ? lsb_id   : slot_id;
        st_go   = (state == IDLE) && rob_st_valid && !mem_st_done;
        ld_go   = (state == IDLE) && !st_go && !flush && (slot_vld || lsb_ready);
        if_go   = (state == IDLE) && !st_go && !ld_go && !flush && if_req && !if_ready;
        ld_done = (state == READ_LD) && !flush && (cnt == acc_len);
        rd_word = acc_data;
        case (cnt)
            3'd1: rd_word[7:0]   = mem_din;
            3'd2: rd_word[15:8]  = mem_din;
            3'd3: rd_word[23:16] = mem_din;
            3'd4: rd_word[31:24] = mem_din;
            default: ;
        endcase
    end

    // One-entry load slot: captures every lsb_ready, consumed when the load starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld  <= 1'b0;
            slot_op   <= '0;
            slot_addr <= '0;
            slot_id   <= '0;
        end else if (flush || ld_go) begin
            slot_vld  <= 1'b0;
        end else if (lsb_ready) begin
            slot_vld  <= 1'b1;
            slot_op   <= lsb_op;
            slot_addr <= lsb_addr;
            slot_id   <= lsb_id;
        end
    end

    // Busy from the cycle after capture until the result cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         mem_busy <= 1'b0;
        else if (flush)     mem_busy <= 1'b0;
        else if (lsb_ready) mem_busy <= 1'b1;
        else if (ld_done)   mem_busy <= 1'b0;
    end

    // Access FSM with registered RAM-side and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            acc_len        <= '0;
            acc_op         <= '0;
            acc_id         <= '0;
            acc_data       <= '0;
            mem_a          <= '0;
            mem_dout       <= '0;
            mem_wr         <= 1'b0;
            mem_data_ready <= 1'b0;
            mem_data       <= '0;
            mem_id         <= '0;
            mem_st_done    <= 1'b0;
            if_ready       <= 1'b0;
            if_inst        <= '0;
        end else begin
            mem_data_ready <= 1'b0;
            mem_st_done    <= 1'b0;
            if_ready       <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (st_go) begin
                        state    <= WRITE;
                        acc_len  <= op_len(rob_st_op);
                        acc_data <= rob_st_data;
                        mem_a    <= rob_st_addr;
                        mem_dout <= rob_st_data[7:0];
                        mem_wr   <= !io_hold(io_buffer_full, rob_st_addr);
                    end else if (ld_go) begin
                        state    <= READ_LD;
                        acc_len  <= op_len(ld_op);
                        acc_op   <= ld_op;
                        acc_id   <= ld_id;
                        acc_data <= '0;
                        mem_a    <= ld_addr;
                    end else if (if_go) begin
                        state    <= READ_IF;
                        acc_len  <= 3'd4;
                        acc_data <= '0;
                        mem_a    <= if_addr;
                    end
                end
                // A byte advances only once it has actually been written
                WRITE: begin
                    if (mem_wr) begin
                        if (cnt == 3'(acc_len - 3'd1)) begin
                            state       <= IDLE;
                            mem_wr      <= 1'b0;
                            mem_st_done <= 1'b1;
                        end else begin
                            cnt      <= cnt + 3'd1;
                            mem_a    <= mem_a + XLEN'(1);
                            acc_data <= acc_data >> 8;
                            mem_dout <= acc_data[15:8];
                            mem_wr   <= !io_hold(io_buffer_full, mem_a + XLEN'(1));
                        end
                    end else begin
                        mem_wr <= !io_hold(io_buffer_full, mem_a);
                    end
                end
                // Byte k arrives one cycle after its address; cnt==N holds the last byte
                READ_LD, READ_IF: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (cnt != 3'd0) acc_data <= rd_word;
                        if (cnt == acc_len) begin
                            state <= IDLE;
                            if (state == READ_LD) begin
                                mem_data_ready <= 1'b1;
                                mem_data       <= load_ext(acc_op, rd_word);
                                mem_id         <= acc_id;
                            end else begin
                                if_ready <= 1'b1;
                                if_inst  <= rd_word;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                            if (cnt < 3'(acc_len - 3'd1)) mem_a <= mem_a + XLEN'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
